alu_iterative_exec: RTL and testbench

Execute-stage ALU that consumes the `o_alu_ctl` / `o_alu_shift` pair produced by the ALU control decoder, together with the two operands from the ID/EX register. Non-shift operations complete in one cycle. Shifts run on an iterative shifter that processes `STEP` bit positions per cycle, which trades a barrel shifter for area. A valid/ready handshake on both sides lets the hazard unit stall the front end while a shift is in flight. The result, plus a zero flag for branch resolution, goes to the EX/MEM register.

---
 rtl/alu_iterative_exec_pkg.sv | 25 ++
 rtl/alu_iterative_exec_comb_core.sv | 34 +++
 rtl/alu_iterative_exec.sv | 107 ++++++++++
 tb/tb_alu_iterative_exec.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_iterative_exec_pkg.sv
// Shared ALU control encodings and execute-stage FSM state codes.
// The ALU_CTL/ALU_SHIFT values must match the ALU control decoder.
package alu_iterative_exec_pkg;

  localparam logic [2:0] ALU_CTL_ADD      = 3'd0;
  localparam logic [2:0] ALU_CTL_SUB      = 3'd1;
  localparam logic [2:0] ALU_CTL_LESS_SIG = 3'd2;
  localparam logic [2:0] ALU_CTL_LESS_UNS = 3'd3;
  localparam logic [2:0] ALU_CTL_AND      = 3'd4;
  localparam logic [2:0] ALU_CTL_OR       = 3'd5;
  localparam logic [2:0] ALU_CTL_XOR      = 3'd6;
  localparam logic [2:0] ALU_CTL_SHIFT    = 3'd7;

  localparam logic [1:0] ALU_SHIFT_SLL    = 2'd0;
  localparam logic [1:0] ALU_SHIFT_SRL    = 2'd1;
  localparam logic [1:0] ALU_SHIFT_SRA    = 2'd2;
  localparam logic [1:0] ALU_SHIFT_NONE   = 2'd3;

  typedef enum logic [1:0] {
    ALU_EXEC_IDLE  = 2'd0,
    ALU_EXEC_SHIFT = 2'd1,
    ALU_EXEC_DONE  = 2'd2
  } alu_exec_state_e;

endpackage

// File: rtl/alu_iterative_exec_comb_core.sv
// Single-cycle WIDTH-bit evaluation of the non-shift ALU operations.
// Also used by the branch comparator, so it stays purely combinational.
module alu_comb_core
  import alu_iterative_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_alu_ctl,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [WIDTH-1:0] o_result
);

  logic lt_sig;
  logic lt_uns;

  assign lt_sig = $signed(i_op_a) < $signed(i_op_b);
  assign lt_uns = i_op_a < i_op_b;

  always_comb begin
    o_result = '0;
    case (i_alu_ctl)
      ALU_CTL_ADD:      o_result = i_op_a + i_op_b;
      ALU_CTL_SUB:      o_result = i_op_a - i_op_b;
      ALU_CTL_LESS_SIG: o_result = {{(WIDTH-1){1'b0}}, lt_sig};
      ALU_CTL_LESS_UNS: o_result = {{(WIDTH-1){1'b0}}, lt_uns};
      ALU_CTL_AND:      o_result = i_op_a & i_op_b;
      ALU_CTL_OR:       o_result = i_op_a | i_op_b;
      ALU_CTL_XOR:      o_result = i_op_a ^ i_op_b;
      default:          o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_iterative_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative shifter that
// moves STEP bit positions per cycle, valid/ready on both sides.
module alu_iterative_exec
  import alu_iterative_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_alu_ctl,
  input  logic [1:0]       i_alu_shift,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  alu_exec_state_e  state_q;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [1:0]       shift_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] core_result;
  logic [CW-1:0]    shamt;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .i_alu_ctl (i_alu_ctl),
    .i_op_a    (i_op_a),
    .i_op_b    (i_op_b),
    .o_result  (core_result)
  );

  assign shamt    = i_op_b[CW-1:0];
  assign o_ready  = (state_q == ALU_EXEC_IDLE);
  assign o_valid  = (state_q == ALU_EXEC_DONE);
  assign o_busy   = (state_q == ALU_EXEC_SHIFT);
  assign o_result = result_q;
  assign o_zero   = (result_q == '0);

  // Up to STEP single-bit shifts per cycle, stopping early once the count runs out.
  always_comb begin
    work_d = work_q;
    rem_d  = rem_q;
    for (int i = 0; i < STEP; i++) begin
      if (rem_d != '0) begin
        case (shift_q)
          ALU_SHIFT_SLL: work_d = {work_d[WIDTH-2:0], 1'b0};
          ALU_SHIFT_SRL: work_d = {1'b0, work_d[WIDTH-1:1]};
          default:       work_d = {work_d[WIDTH-1], work_d[WIDTH-1:1]};
        endcase
        rem_d = rem_d - CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ALU_EXEC_IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      shift_q  <= ALU_SHIFT_SLL;
      result_q <= '0;
    end else begin
      case (state_q)
        ALU_EXEC_IDLE: begin
          if (i_valid) begin
            if (i_alu_ctl != ALU_CTL_SHIFT) begin
              result_q <= core_result;
              state_q  <= ALU_EXEC_DONE;
            end else if (i_alu_shift == ALU_SHIFT_NONE || shamt == '0) begin
              result_q <= i_op_a;
              state_q  <= ALU_EXEC_DONE;
            end else begin
              work_q  <= i_op_a;
              rem_q   <= shamt;
              shift_q <= i_alu_shift;
              state_q <= ALU_EXEC_SHIFT;
            end
          end
        end
        ALU_EXEC_SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            result_q <= work_d;
            state_q  <= ALU_EXEC_DONE;
          end
        end
        ALU_EXEC_DONE: begin
          // No bypass: the next accept waits for IDLE.
          if (i_ready) state_q <= ALU_EXEC_IDLE;
        end
        default: state_q <= ALU_EXEC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Scoreboard bench for alu_iterative_exec: driver pushes reference results,
// monitor pops and compares whenever the DUT presents a result.
module tb_alu_iterative_exec;
  import alu_iterative_exec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_valid, o_ready, o_valid, i_ready, o_zero, o_busy;
  logic [2:0]  i_ctl;
  logic [1:0]  i_sh;
  logic [31:0] i_a, i_b, o_result;

  logic        d4_valid, d4_ready, d4_ovalid, d4_zero, d4_busy;
  logic [2:0]  d4_ctl;
  logic [1:0]  d4_sh;
  logic [31:0] d4_a, d4_b, d4_res;

  alu_iterative_exec #(.WIDTH(32), .STEP(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_ctl(i_ctl), .i_alu_shift(i_sh), .i_op_a(i_a), .i_op_b(i_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_zero(o_zero), .o_busy(o_busy)
  );

  alu_iterative_exec #(.WIDTH(32), .STEP(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(d4_valid), .o_ready(d4_ready),
    .i_alu_ctl(d4_ctl), .i_alu_shift(d4_sh), .i_op_a(d4_a), .i_op_b(d4_b),
    .o_valid(d4_ovalid), .i_ready(1'b1), .o_result(d4_res),
    .o_zero(d4_zero), .o_busy(d4_busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] c, input logic [1:0] s,
                                             input logic [31:0] a, input logic [31:0] b);
    int k;
    k = int'(b[4:0]);
    case (c)
      ALU_CTL_ADD:      return a + b;
      ALU_CTL_SUB:      return a - b;
      ALU_CTL_LESS_SIG: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_CTL_LESS_UNS: return (a < b) ? 32'd1 : 32'd0;
      ALU_CTL_AND:      return a & b;
      ALU_CTL_OR:       return a | b;
      ALU_CTL_XOR:      return a ^ b;
      default: begin
        case (s)
          ALU_SHIFT_SLL: return a << k;
          ALU_SHIFT_SRL: return a >> k;
          ALU_SHIFT_SRA: return 32'($signed(a) >>> k);
          default:       return a;
        endcase
      end
    endcase
  endfunction

  function automatic int ref_busy(input logic [2:0] c, input logic [1:0] s,
                                  input logic [31:0] b, input int step);
    int k;
    k = int'(b[4:0]);
    if (c == ALU_CTL_SHIFT && s != ALU_SHIFT_NONE && k != 0) return (k + step - 1) / step;
    return 0;
  endfunction

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          busy;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: random ready, 1: hold ready low, 2: hold ready high
  int bp = 0;
  always @(posedge clk) begin
    #1;
    if (bp == 1) i_ready = 1'b0;
    else if (bp == 2) i_ready = 1'b1;
    else i_ready = ($urandom_range(0, 3) != 0);
  end

  bit          mon_en = 1'b1;
  bit          seen = 1'b0;
  int          busy_cnt = 0;
  logic [31:0] held;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (o_busy) busy_cnt++;
      if (o_valid && !seen) begin
        seen = 1'b1;
        held = o_result;
        if (sb.size() == 0) chk("unexpected_valid", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          chk("result", o_result, e.res);
          chk("zero", {31'b0, o_zero}, {31'b0, e.res == 32'd0});
          chk("latency", 32'(cyc - e.acc), 32'(1 + e.busy));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
        end
        busy_cnt = 0;
      end else if (o_valid) begin
        chk("hold_result", o_result, held);
      end
      if (o_valid && i_ready) seen = 1'b0;
    end
  end

  task automatic issue(input logic [2:0] c, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] b, input bit track);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!o_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!o_ready) begin
      chk("ready_timeout", {31'b0, o_ready}, 32'd1);
      return;
    end
    i_ctl = c; i_sh = s; i_a = a; i_b = b; i_valid = 1'b1;
    if (track) begin
      e.res  = ref_result(c, s, a, b);
      e.acc  = cyc;
      e.busy = ref_busy(c, s, b, 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !o_ready) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic run4(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    int start, guard;
    @(negedge clk);
    chk("s4_ready", {31'b0, d4_ready}, 32'd1);
    d4_ctl = ALU_CTL_SHIFT; d4_sh = s; d4_a = a; d4_b = b; d4_valid = 1'b1;
    start = cyc;
    @(posedge clk);
    #1 d4_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!d4_ovalid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("s4_latency", 32'(cyc - start), 32'(1 + ref_busy(ALU_CTL_SHIFT, s, b, 4)));
    chk("s4_result", d4_res, ref_result(ALU_CTL_SHIFT, s, a, b));
  endtask

  initial begin
    int guard;
    logic [2:0]  c;
    logic [1:0]  s;
    logic [31:0] a, b;
    logic [31:0] corner [4];
    corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;

    i_valid = 0; i_ctl = 0; i_sh = 0; i_a = 0; i_b = 0; i_ready = 0;
    d4_valid = 0; d4_ctl = 0; d4_sh = 0; d4_a = 0; d4_b = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_busy",  {31'b0, o_busy},  32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_zero",  {31'b0, o_zero},  32'd1);
    rst_n = 1'b1;

    issue(ALU_CTL_ADD,      ALU_SHIFT_SLL,  32'hFFFF_FFFF, 32'd1, 1);
    issue(ALU_CTL_LESS_SIG, ALU_SHIFT_SLL,  32'h8000_0000, 32'd1, 1);
    issue(ALU_CTL_LESS_UNS, ALU_SHIFT_SLL,  32'h8000_0000, 32'd1, 1);
    issue(ALU_CTL_SHIFT,    ALU_SHIFT_SRA,  32'h8000_0000, 32'd31, 1);
    issue(ALU_CTL_SHIFT,    ALU_SHIFT_SRL,  32'h8000_0000, 32'd31, 1);
    issue(ALU_CTL_SHIFT,    ALU_SHIFT_SLL,  32'd1, 32'd0, 1);
    issue(ALU_CTL_SHIFT,    ALU_SHIFT_NONE, 32'h1234_5678, 32'd9, 1);
    issue(ALU_CTL_SHIFT,    ALU_SHIFT_SLL,  32'h0000_0003, 32'hFFFF_FFE4, 1);
    issue(ALU_CTL_SUB,      ALU_SHIFT_SLL,  32'd0, 32'd1, 1);
    drain();

    run4(ALU_SHIFT_SLL, 32'd1, 32'd5);
    run4(ALU_SHIFT_SRA, 32'h8000_0000, 32'd31);
    run4(ALU_SHIFT_SRL, 32'hF000_0000, 32'd7);
    run4(ALU_SHIFT_SLL, 32'd1, 32'd0);
    run4(ALU_SHIFT_SRA, 32'h8765_4321, 32'd4);

    // Back-pressure with garbage offered during DONE, then a handshake with i_valid still high.
    bp = 1;
    issue(ALU_CTL_OR, ALU_SHIFT_SLL, 32'h00FF_0000, 32'h0000_00FF, 1);
    guard = 0;
    @(negedge clk);
    while (!o_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      i_ctl = 3'($urandom_range(0, 7)); i_sh = 2'($urandom_range(0, 3));
      i_a = $urandom; i_b = $urandom; i_valid = 1'b1;
      chk("bp_ready_low", {31'b0, o_ready}, 32'd0);
      chk("bp_valid_high", {31'b0, o_valid}, 32'd1);
      @(negedge clk);
    end
    bp = 2;
    @(negedge clk);
    chk("bp_valid_before_release", {31'b0, o_valid}, 32'd1);
    @(negedge clk);
    chk("no_bypass_ready", {31'b0, o_ready}, 32'd1);
    chk("no_bypass_valid", {31'b0, o_valid}, 32'd0);
    i_valid = 1'b0;
    bp = 0;
    issue(ALU_CTL_AND, ALU_SHIFT_SLL, 32'hF0F0_F0F0, 32'hFF00_FF00, 1);

    for (int n = 0; n < 150; n++) begin
      c = 3'($urandom_range(0, 7));
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      issue(c, s, a, b, 1);
    end
    drain();

    // Reset in the 10th cycle of a 20-bit shift; the result must never appear.
    mon_en = 1'b0;
    issue(ALU_CTL_SHIFT, ALU_SHIFT_SLL, 32'h0000_00A5, 32'd20, 0);
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'b0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready",  {31'b0, o_ready}, 32'd1);
    chk("mid_rst_valid",  {31'b0, o_valid}, 32'd0);
    chk("mid_rst_busy",   {31'b0, o_busy},  32'd0);
    chk("mid_rst_result", o_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    busy_cnt = 0;
    mon_en = 1'b1;
    issue(ALU_CTL_XOR, ALU_SHIFT_SLL, 32'h0000_F0F0, 32'h0000_0FF0, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
